// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display feeder.
package display_pkg;

  localparam int BCD_W          = 4;
  localparam int DEF_NUM_DIGITS = 4;

  // Wide enough for any practical digit count; slice to the anode width in use.
  localparam logic [31:0] ANODE_OFF = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Largest value displayable on n digits (MAX_DISP for a given digit count).
  function automatic int max_disp(input int n);
    return pow10(n) - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 iteration per clock,
// with saturation to all-9s and a held result (display) register.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int BIN_W      = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BIN_W-1:0]              value,
  input  logic                          load,
  output logic                          busy,
  output logic                          ovf,
  output logic [BCD_W*NUM_DIGITS-1:0]   bcd,
  output logic                          done
);

  localparam int          BCD_TOT = BCD_W * NUM_DIGITS;
  localparam int          ITER_W  = $clog2(BIN_W + 1);
  localparam logic [31:0] SAT_VAL = 32'(max_disp(NUM_DIGITS));

  conv_state_e          state, state_d;
  logic [BIN_W-1:0]     shreg;
  logic [BCD_TOT-1:0]   scratch, adj;
  logic [ITER_W-1:0]    iter;
  logic                 sat, sat_q;

  assign sat  = 32'(value) > SAT_VAL;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned; a missing default is how combinational blocks grow latches.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (load) state_d = CONV;
      CONV:    if (iter == ITER_W'(BIN_W - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Add 3 to every nibble >= 5 ahead of the shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scratch[i*BCD_W +: BCD_W] >= BCD_W'(5))
        adj[i*BCD_W +: BCD_W] = scratch[i*BCD_W +: BCD_W] + BCD_W'(3);
    end
  end

  // NOTE: the datapath and result register are reset too, so an aborted
  // conversion can never leak a partial value onto the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      scratch <= '0;
      iter    <= '0;
      sat_q   <= 1'b0;
      ovf     <= 1'b0;
      bcd     <= '0;
    end else begin
      unique case (state)
        IDLE: if (load) begin
          shreg   <= sat ? BIN_W'(SAT_VAL) : value;
          scratch <= '0;
          iter    <= '0;
          sat_q   <= sat;
        end
        CONV: begin
          {scratch, shreg} <= {adj, shreg} << 1;
          iter             <= iter + ITER_W'(1);
        end
        DONE: begin
          bcd <= scratch;
          ovf <= sat_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Display feeder top: binary-to-BCD conversion plus free-running digit scan
// with registered digit/anode outputs and optional leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      value,
  input  logic                  load,
  output logic                  busy,
  output logic                  ovf,
  output logic [BCD_W-1:0]      digit,
  output logic [NUM_DIGITS-1:0] anode
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] ALL_OFF   = ANODE_OFF[NUM_DIGITS-1:0];
  localparam logic [NUM_DIGITS-1:0] ANODE_RST = ALL_OFF & ~NUM_DIGITS'(1);

  logic [BCD_W*NUM_DIGITS-1:0] bcd;
  logic                        done;
  logic [CNT_W-1:0]            cnt;
  logic [IDX_W-1:0]            idx;
  logic [NUM_DIGITS-1:0]       lz, anode_d;
  logic [BCD_W-1:0]            digit_d;
  logic                        seen_nz;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .busy  (busy),
    .ovf   (ovf),
    .bcd   (bcd),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    seen_nz = 1'b0;
    lz      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (bcd[i*BCD_W +: BCD_W] != '0) seen_nz = 1'b1;
      lz[i] = !seen_nz && (i != 0);
    end
  end

  always_comb begin
    digit_d = bcd[int'(idx)*BCD_W +: BCD_W];
    anode_d = ALL_OFF;
    if (!((LZ_BLANK != 0) && lz[idx])) anode_d[idx] = 1'b0;
  end

  // Digit and anode share one register stage so they always switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
      anode <= ANODE_RST;
    end else begin
      digit <= digit_d;
      anode <= anode_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench: table of conversions with a scoreboard queue, plus
// hand-written sequences for reset, ignored loads and aborted conversions.
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int BW = 14;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [BW-1:0] value = '0;
  logic          busy0, ovf0, busy1, ovf1;
  logic [3:0]    digit0, digit1;
  logic [ND-1:0] anode0, anode1;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy0), .ovf(ovf0), .digit(digit0), .anode(anode0));

  display_scan_ctrl #(.NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD), .LZ_BLANK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy1), .ovf(ovf1), .digit(digit1), .anode(anode1));

  typedef struct {
    int         value;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name, input logic [31:0] act);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out, last value %0h", name, act);
  endtask

  function automatic logic [3:0] lz_anode(input logic [15:0] bcd, input int s);
    logic [3:0] a;
    logic       blank;
    a    = 4'b1111;
    a[s] = 1'b0;
    if (s != 0) begin
      blank = 1'b1;
      for (int j = s; j < ND; j++) if (bcd[j*4 +: 4] != 4'd0) blank = 1'b0;
      if (blank) a = 4'b1111;
    end
    return a;
  endfunction

  // Sync to the start of slot 0, then check one full rotation cycle by cycle.
  task automatic check_scan(input string tag, input logic [15:0] bcd);
    int t;
    logic [3:0] a;
    t = 0;
    while (anode0 !== 4'b0111 && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) fail_timeout({tag, "_sync3"}, 32'(anode0));
    t = 0;
    while (anode0 === 4'b0111 && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) fail_timeout({tag, "_sync0"}, 32'(anode0));
    for (int s = 0; s < ND; s++) begin
      a    = 4'b1111;
      a[s] = 1'b0;
      for (int c = 0; c < RD; c++) begin
        check($sformatf("%s_s%0d_c%0d_anode", tag, s, c), 32'(anode0), 32'(a));
        check($sformatf("%s_s%0d_c%0d_digit", tag, s, c), 32'(digit0), 32'(bcd[s*4 +: 4]));
        check($sformatf("%s_s%0d_c%0d_lzanode", tag, s, c), 32'(anode1), 32'(lz_anode(bcd, s)));
        check($sformatf("%s_s%0d_c%0d_lzdigit", tag, s, c), 32'(digit1), 32'(bcd[s*4 +: 4]));
        @(negedge clk);
      end
    end
  endtask

  // Strobe one load, optionally a second one d cycles later, and count busy cycles.
  task automatic run_conv(input vec_t e, input bit extra, input int d, input int v2,
                          output int cycles);
    int k;
    @(negedge clk);
    value = BW'(e.value);
    load  = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    load = 1'b0;
    k = 0;
    while (busy0 && k < 100) begin
      if (extra && k == d - 1) begin
        value = BW'(v2);
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    load   = 1'b0;
    cycles = k;
  endtask

  task automatic check_done(input string tag, input int cycles);
    vec_t e;
    check({tag, "_busy_cycles"}, 32'(cycles), 32'd15);
    check({tag, "_busy1"}, 32'(busy1), 32'd0);
    if (sb.size() == 0) begin
      fail_timeout({tag, "_scoreboard_empty"}, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_ovf"}, 32'(ovf0), 32'(e.ovf));
      check({tag, "_lzovf"}, 32'(ovf1), 32'(e.ovf));
      check_scan(tag, e.bcd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    vec_t e;

    vecs.push_back('{1234,  16'h1234, 1'b0});
    vecs.push_back('{12000, 16'h9999, 1'b1});
    vecs.push_back('{5,     16'h0005, 1'b0});
    vecs.push_back('{7,     16'h0007, 1'b0});
    vecs.push_back('{0,     16'h0000, 1'b0});
    vecs.push_back('{808,   16'h0808, 1'b0});
    vecs.push_back('{9999,  16'h9999, 1'b0});
    vecs.push_back('{10000, 16'h9999, 1'b1});
    vecs.push_back('{16383, 16'h9999, 1'b1});

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_anode", 32'(anode0), 32'h000e);
    check("rst_digit", 32'(digit0), 32'h0);
    check("rst_busy",  32'(busy0),  32'h0);
    check("rst_ovf",   32'(ovf0),   32'h0);
    check("rst_lzanode", 32'(anode1), 32'h000e);
    rst_n = 1'b1;
    check_scan("zero", 16'h0000);

    // Conversion table
    foreach (vecs[i]) begin
      run_conv(vecs[i], 1'b0, 0, 0, cyc);
      check_done($sformatf("vec%0d_%0d", i, vecs[i].value), cyc);
    end

    // Asynchronous reset mid-scan while ovf is set
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_anode", 32'(anode0), 32'h000e);
    check("arst_digit", 32'(digit0), 32'h0);
    check("arst_busy",  32'(busy0),  32'h0);
    check("arst_ovf",   32'(ovf0),   32'h0);
    repeat (3) @(negedge clk);
    check("arst_hold_anode", 32'(anode0), 32'h000e);
    check("arst_hold_digit", 32'(digit0), 32'h0);
    rst_n = 1'b1;
    check_scan("arst", 16'h0000);

    // Second load while busy is ignored
    e = '{42, 16'h0042, 1'b0};
    run_conv(e, 1'b1, 3, 99, cyc);
    check_done("ignore99", cyc);

    // Load landing on the DONE cycle is ignored and does not restart
    e = '{1234, 16'h1234, 1'b0};
    run_conv(e, 1'b1, 15, 77, cyc);
    check("collide_no_restart", 32'(busy0), 32'h0);
    check_done("collide", cyc);

    // Reset pulse mid-conversion aborts cleanly
    @(negedge clk);
    value = BW'(8888);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_mid", 32'(busy0), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy_rst", 32'(busy0), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_busy_after", 32'(busy0), 32'h0);
    check("abort_ovf", 32'(ovf0), 32'h0);
    check_scan("abort", 16'h0000);
    e = '{5, 16'h0005, 1'b0};
    run_conv(e, 1'b0, 0, 0, cyc);
    check_done("post_abort5", cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
